// File: rtl/batpu_mem_pkg.sv
// Shared types and widths for the instruction-memory responder and its store.
package batpu_mem_pkg;

  localparam int INST_AW = 10;
  localparam int INST_DW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_t;

  typedef logic [INST_AW-1:0] inst_addr_t;
  typedef logic [INST_DW-1:0] inst_word_t;

endpackage

// File: rtl/inst_ram.sv
// Instruction store: one write port, one registered read port, write-first on
// a same-address collision. All activity is gated by the global clock enable.
module inst_ram
  import batpu_mem_pkg::*;
#(
  parameter int AW    = INST_AW,
  parameter int DW    = INST_DW,
  parameter int DEPTH = 1 << AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q, rdata_d;

  // NOTE: the array carries no reset so it maps onto block RAM; only the read register is reset.
  always_ff @(posedge clk) begin
    if (en && we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (en && re) rdata_d = (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/inst_mem_responder.sv
// Memory-side responder for icache instruction fetches with programmable store.
// Optional next-word prefetch buffer enabled by defining INST_MEM_PREFETCH_EN.
module inst_mem_responder
  import batpu_mem_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int AW      = INST_AW,
  parameter int DW      = INST_DW
) (
  input  logic          clk,
  input  logic          async_rst,
  input  logic          clk_en,
  input  logic          inst_mem_req,
  input  logic [AW-1:0] inst_address,
  output logic [DW-1:0] inst_in,
  output logic          inst_valid,
  output logic          busy,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_address,
  input  logic [DW-1:0] prog_data
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  resp_state_t   state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] req_addr_q, req_addr_d;
  logic [DW-1:0] hold_q, hold_d;

  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          pf_hit;

`ifdef INST_MEM_PREFETCH_EN
  logic          pf_valid_q, pf_valid_d;
  logic [AW-1:0] pf_addr_q, pf_addr_d;

  // The RAM read register doubles as the prefetch buffer: nothing else reads
  // the store between leaving RESP and the next accept.
  assign pf_hit = pf_valid_q && (inst_address == pf_addr_q)
                  && !(prog_we && (prog_address == pf_addr_q));
`else
  assign pf_hit = 1'b0;
`endif

  inst_ram #(.AW(AW), .DW(DW)) u_ram (
    .clk   (clk),
    .rst   (async_rst),
    .en    (clk_en),
    .we    (prog_we),
    .waddr (prog_address),
    .wdata (prog_data),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_addr_d = req_addr_q;
    hold_d     = hold_q;
    rd_en      = 1'b0;
    rd_addr    = req_addr_q;

    unique case (state_q)
      IDLE: begin
        if (inst_mem_req) begin
          req_addr_d = inst_address;
          if (pf_hit) begin
            state_d = RESP;
          end else if (LATENCY == 1) begin
            state_d = RESP;
            rd_en   = 1'b1;
            rd_addr = inst_address;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          rd_en   = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        hold_d  = rd_data;
`ifdef INST_MEM_PREFETCH_EN
        rd_en   = 1'b1;
        rd_addr = req_addr_q + AW'(1);
`endif
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef INST_MEM_PREFETCH_EN
  always_comb begin
    pf_valid_d = pf_valid_q;
    pf_addr_d  = pf_addr_q;
    if (prog_we && (prog_address == pf_addr_q)) pf_valid_d = 1'b0;
    if ((state_q == IDLE) && inst_mem_req && !pf_hit) pf_valid_d = 1'b0;
    if (state_q == RESP) begin
      pf_valid_d = 1'b1;
      pf_addr_d  = req_addr_q + AW'(1);
    end
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      pf_valid_q <= 1'b0;
      pf_addr_q  <= '0;
    end else if (clk_en) begin
      pf_valid_q <= pf_valid_d;
      pf_addr_q  <= pf_addr_d;
    end
  end
`endif

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_addr_q <= '0;
      hold_q     <= '0;
    end else if (clk_en) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_addr_q <= req_addr_d;
      hold_q     <= hold_d;
    end
  end

  assign inst_valid = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign inst_in    = (state_q == RESP) ? rd_data : hold_q;

endmodule

// File: doc/inst_mem_responder.md
Name: inst_mem_responder

Overview:
- Memory-side responder for the instruction-fetch interface driven by the icache (inst_mem_req / inst_address / inst_in).
- Holds a 1024x16 instruction store, loaded through a program port.
- Answers each accepted fetch with one 16-bit word after a configurable latency, flagged by a one-cycle inst_valid strobe.
- Sits beside the CPU top level and is the fill source for the icache.

Parameters:
- LATENCY, 2, enabled-clock cycles from request acceptance to inst_valid; legal range 1..15.
- AW, 10, instruction address width.
- DW, 16, instruction word width.

Ports:
- clk  in  1  system clock, rising edge
- async_rst  in  1  asynchronous active-high reset
- clk_en  in  1  global clock enable; low freezes all state and outputs
- inst_mem_req  in  1  fetch request from icache, level, held until inst_valid
- inst_address  in  AW  fetch word address
- inst_in  out  DW  returned instruction word
- inst_valid  out  1  one-cycle strobe, inst_in valid
- busy  out  1  high while a fetch is outstanding (WAIT or RESP)
- prog_we  in  1  program-port write enable
- prog_address  in  AW  program-port word address
- prog_data  in  DW  program-port write data

Behaviour:
- Reset (async_rst high, any time including mid-fetch):
  - state=IDLE; inst_valid=0; inst_in=0; busy=0; latency counter=0.
  - Store contents are not reset.
  - In-flight fetch is dropped. The requester must re-request.
- Nothing advances on a clock edge with clk_en=0. Outputs hold their values.
- FSM states: IDLE, WAIT, RESP.
  - IDLE -> WAIT when inst_mem_req=1. Accepts: latch inst_address into req_addr, load cnt=LATENCY-1, busy=1.
  - If LATENCY=1, IDLE -> RESP directly. The store is read at req_addr on the accept edge.
  - WAIT: cnt decrements each enabled cycle. When cnt=1, the store read is issued and the next state is RESP.
  - RESP: inst_valid=1 and inst_in=word for exactly one enabled cycle. Next state is IDLE.
  - inst_in holds its last value after RESP; it is not cleared.
- Latency: inst_valid rises exactly LATENCY enabled cycles after the accept edge.
- Minimum spacing between accepts is LATENCY+1 cycles, because RESP returns to IDLE before the next accept.
- inst_mem_req deasserted while in WAIT: the fetch still completes and inst_valid still pulses. The responder never cancels a fetch.
- inst_address changing after accept is ignored. req_addr is used.
- Program port:
  - Write occurs on any enabled edge with prog_we=1, in any state.
  - A write and a store read to the same address on the same edge return prog_data (write-first forwarding).
- Address arithmetic is AW-bit unsigned and wraps: 1023+1=0.

Optional Feature:
- Macro: INST_MEM_PREFETCH_EN.
- When defined:
  - On leaving RESP for address A, the block reads A+1 (wrapping) into pf_buf and sets pf_addr=A+1, pf_valid=1.
  - A request in IDLE with inst_address==pf_addr and pf_valid=1 goes IDLE -> RESP with pf_buf, giving a latency of 1.
  - A miss follows the normal path and clears pf_valid.
  - A prog write to pf_addr clears pf_valid.
  - Reset clears pf_valid.
- When not defined: no prefetch buffer exists, and every fetch takes LATENCY cycles.

Decomposition:
- Package batpu_mem_pkg:
  - INST_AW=10, INST_DW=16.
  - typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_t.
  - typedef logic [INST_AW-1:0] inst_addr_t; typedef logic [INST_DW-1:0] inst_word_t.
- One sub-module, inst_ram:
  - Single write port, single synchronous read port.
  - Write-first forwarding on same-address collision.
- The responder holds the FSM, counter and prefetch logic.

Test Plan:
- Load addr 5 = 16'hA5C3, LATENCY=2, then req addr 5 -> inst_valid rises 2 enabled cycles after accept with inst_in=16'hA5C3, busy high during WAIT and RESP.
- Same fetch with clk_en held low for 3 cycles while in WAIT -> inst_valid delayed by exactly 3 cycles; inst_in and busy frozen during the stall.
- Assert async_rst mid-WAIT -> inst_valid=0, busy=0, inst_in=0 immediately. A new req addr 7 is then served normally.
- prog_we to addr 9 with 16'h1234 on the same edge the store read of addr 9 is issued -> inst_in=16'h1234.
- With INST_MEM_PREFETCH_EN, fetch 1023 then fetch 0 -> second inst_valid 1 cycle after accept (wrap prefetch hit). A prog write to addr 0 before the second fetch forces the full LATENCY.
- Back-to-back fetches of addrs 0..3 with req held high -> four inst_valid pulses spaced LATENCY+1 cycles apart, correct data for each.
